// File: rtl/exc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// exc_ctrl_pkg : ExcCode values, CP0 bit positions and FSM encoding
// Revision     : 1.0
// ============================================================================
package exc_ctrl_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;
    localparam int STATUS_IM_LSB  = 8;

    localparam logic BADV_SEL_PC   = 1'b0;
    localparam logic BADV_SEL_DATA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_DRAIN  = 2'd2
    } exc_state_e;

    typedef struct packed {
        logic       hit;
        logic       is_eret;
        logic [4:0] code;
        logic       badvaddr_we;
        logic       badvaddr_sel;
    } prio_res_t;

endpackage
`default_nettype wire

// File: rtl/exc_prio_enc.sv
`default_nettype none
// ============================================================================
// exc_prio_enc : picks the highest-priority exception (or ERET) for MEM
// Revision     : 1.0
// ============================================================================
module exc_prio_enc
    import exc_ctrl_pkg::*;
(
    input  logic      irq_i,
    input  logic      adel_if_i,
    input  logic      ri_i,
    input  logic      ov_i,
    input  logic      sys_i,
    input  logic      bp_i,
    input  logic      adel_ld_i,
    input  logic      ades_i,
    input  logic      eret_i,
    output prio_res_t res_o
);

    always_comb begin
        res_o = '0;
        res_o.hit = 1'b1;
        if (irq_i) begin
            res_o.code = EXC_INT;
        end else if (adel_if_i) begin
            res_o.code         = EXC_ADEL;
            res_o.badvaddr_we  = 1'b1;
            res_o.badvaddr_sel = BADV_SEL_PC;
        end else if (ri_i) begin
            res_o.code = EXC_RI;
        end else if (ov_i) begin
            res_o.code = EXC_OV;
        end else if (sys_i) begin
            res_o.code = EXC_SYS;
        end else if (bp_i) begin
            res_o.code = EXC_BP;
        end else if (adel_ld_i) begin
            res_o.code         = EXC_ADEL;
            res_o.badvaddr_we  = 1'b1;
            res_o.badvaddr_sel = BADV_SEL_DATA;
        end else if (ades_i) begin
            res_o.code         = EXC_ADES;
            res_o.badvaddr_we  = 1'b1;
            res_o.badvaddr_sel = BADV_SEL_DATA;
        end else if (eret_i) begin
            res_o.is_eret = 1'b1;
        end else begin
            res_o.hit = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// exc_ctrl : MEM-stage exception controller (CP0 commit, flush, drain window)
// Revision : 1.0
// ============================================================================
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          DRAIN_CYCLES = 2,
    parameter int          HW_INT_W     = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_valid_i,
    input  logic [31:0]         mem_pc_i,
    input  logic                mem_in_delayslot_i,
    input  logic                mem_eret_i,
    input  logic                mem_syscall_i,
    input  logic                mem_break_i,
    input  logic                mem_ri_i,
    input  logic                mem_ov_i,
    input  logic                mem_adel_if_i,
    input  logic                mem_adel_ld_i,
    input  logic                mem_ades_i,
    input  logic [31:0]         mem_bad_vaddr_i,
    input  logic [HW_INT_W-1:0] hw_int_i,
    input  logic [31:0]         cp0_status_i,
    input  logic [1:0]          cp0_cause_ip_sw_i,
    input  logic [31:0]         cp0_epc_i,
    output logic                flush_o,
    output logic [31:0]         redirect_pc_o,
    output logic                cp0_exc_we_o,
    output logic [4:0]          cp0_exc_code_o,
    output logic                cp0_exc_bd_o,
    output logic [31:0]         cp0_exc_epc_o,
    output logic                cp0_badvaddr_we_o,
    output logic [31:0]         cp0_badvaddr_o,
    output logic                cp0_eret_we_o,
    output logic [HW_INT_W-1:0] cp0_ip_hw_o,
    output logic                mem_kill_o
);

    localparam int IP_W = HW_INT_W + 2;

    exc_state_e          state_q;
    logic [2:0]          drain_cnt_q;
    logic [HW_INT_W-1:0] int_s1_q;
    logic [HW_INT_W-1:0] int_s2_q;

    logic                flush_q;
    logic [31:0]         redirect_q;
    logic                exc_we_q;
    logic [4:0]          exc_code_q;
    logic                exc_bd_q;
    logic [31:0]         exc_epc_q;
    logic                badv_we_q;
    logic [31:0]         badv_q;
    logic                eret_we_q;

    logic                irq;
    logic                event_hit;
    logic [31:0]         epc_calc;
    logic [IP_W-1:0]     ip_all;
    prio_res_t           prio;
    logic                unused_status;

    assign unused_status = ^{cp0_status_i[31:16], cp0_status_i[7:2]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            int_s1_q <= '0;
            int_s2_q <= '0;
        end else begin
            int_s1_q <= hw_int_i;
            int_s2_q <= int_s1_q;
        end
    end

    assign ip_all = {int_s2_q, cp0_cause_ip_sw_i};
    assign irq    = cp0_status_i[STATUS_IE_BIT] & ~cp0_status_i[STATUS_EXL_BIT]
                  & |(ip_all & cp0_status_i[STATUS_IM_LSB +: IP_W]);

    exc_prio_enc u_prio (
        .irq_i     (irq),
        .adel_if_i (mem_adel_if_i),
        .ri_i      (mem_ri_i),
        .ov_i      (mem_ov_i),
        .sys_i     (mem_syscall_i),
        .bp_i      (mem_break_i),
        .adel_ld_i (mem_adel_ld_i),
        .ades_i    (mem_ades_i),
        .eret_i    (mem_eret_i),
        .res_o     (prio)
    );

    assign event_hit  = rst & mem_valid_i & (state_q == ST_IDLE) & prio.hit;
    assign mem_kill_o = event_hit;
    assign epc_calc   = mem_in_delayslot_i ? (mem_pc_i - 32'd4) : mem_pc_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= '0;
            flush_q     <= 1'b0;
            redirect_q  <= '0;
            exc_we_q    <= 1'b0;
            exc_code_q  <= '0;
            exc_bd_q    <= 1'b0;
            exc_epc_q   <= '0;
            badv_we_q   <= 1'b0;
            badv_q      <= '0;
            eret_we_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (event_hit) begin
                        flush_q <= 1'b1;
                        state_q <= ST_COMMIT;
                        if (prio.is_eret) begin
                            eret_we_q  <= 1'b1;
                            redirect_q <= cp0_epc_i;
                        end else begin
                            exc_we_q   <= 1'b1;
                            redirect_q <= EXC_VECTOR;
                            exc_code_q <= prio.code;
                            exc_bd_q   <= mem_in_delayslot_i;
                            exc_epc_q  <= epc_calc;
                            badv_we_q  <= prio.badvaddr_we;
                            if (prio.badvaddr_we) begin
                                badv_q <= (prio.badvaddr_sel == BADV_SEL_DATA)
                                          ? mem_bad_vaddr_i : mem_pc_i;
                            end
                        end
                    end
                end
                ST_COMMIT: begin
                    flush_q    <= 1'b0;
                    redirect_q <= '0;
                    exc_we_q   <= 1'b0;
                    exc_code_q <= '0;
                    exc_bd_q   <= 1'b0;
                    exc_epc_q  <= '0;
                    badv_we_q  <= 1'b0;
                    badv_q     <= '0;
                    eret_we_q  <= 1'b0;
                    // COMMIT itself is the first masked cycle of the window
                    if (DRAIN_CYCLES > 1) begin
                        state_q     <= ST_DRAIN;
                        drain_cnt_q <= 3'(DRAIN_CYCLES - 1);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt_q <= drain_cnt_q - 3'd1;
                    if (drain_cnt_q - 3'd1 == 3'd0) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign flush_o           = flush_q;
    assign redirect_pc_o     = redirect_q;
    assign cp0_exc_we_o      = exc_we_q;
    assign cp0_exc_code_o    = exc_code_q;
    assign cp0_exc_bd_o      = exc_bd_q;
    assign cp0_exc_epc_o     = exc_epc_q;
    assign cp0_badvaddr_we_o = badv_we_q;
    assign cp0_badvaddr_o    = badv_q;
    assign cp0_eret_we_o     = eret_we_q;
    assign cp0_ip_hw_o       = int_s2_q;

endmodule
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// ============================================================================
// tb_exc_ctrl : scoreboard bench for exc_ctrl with a behavioural model
// Revision    : 1.0
// ============================================================================
module tb_exc_ctrl;

    localparam int          DRAIN = 2;
    localparam logic [31:0] VEC   = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid_i = 1'b0, mem_in_delayslot_i = 1'b0;
    logic        mem_eret_i = 1'b0, mem_syscall_i = 1'b0, mem_break_i = 1'b0, mem_ri_i = 1'b0;
    logic        mem_ov_i = 1'b0, mem_adel_if_i = 1'b0, mem_adel_ld_i = 1'b0, mem_ades_i = 1'b0;
    logic [31:0] mem_pc_i = '0, mem_bad_vaddr_i = '0, cp0_status_i = '0, cp0_epc_i = '0;
    logic [5:0]  hw_int_i = '0;
    logic [1:0]  cp0_cause_ip_sw_i = '0;
    logic        flush_o, cp0_exc_we_o, cp0_exc_bd_o, cp0_badvaddr_we_o, cp0_eret_we_o, mem_kill_o;
    logic [31:0] redirect_pc_o, cp0_exc_epc_o, cp0_badvaddr_o;
    logic [4:0]  cp0_exc_code_o;
    logic [5:0]  cp0_ip_hw_o;

    exc_ctrl #(.EXC_VECTOR(VEC), .DRAIN_CYCLES(DRAIN), .HW_INT_W(6)) dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i), .mem_in_delayslot_i(mem_in_delayslot_i),
        .mem_eret_i(mem_eret_i), .mem_syscall_i(mem_syscall_i), .mem_break_i(mem_break_i),
        .mem_ri_i(mem_ri_i), .mem_ov_i(mem_ov_i), .mem_adel_if_i(mem_adel_if_i),
        .mem_adel_ld_i(mem_adel_ld_i), .mem_ades_i(mem_ades_i), .mem_bad_vaddr_i(mem_bad_vaddr_i),
        .hw_int_i(hw_int_i), .cp0_status_i(cp0_status_i), .cp0_cause_ip_sw_i(cp0_cause_ip_sw_i),
        .cp0_epc_i(cp0_epc_i), .flush_o(flush_o), .redirect_pc_o(redirect_pc_o),
        .cp0_exc_we_o(cp0_exc_we_o), .cp0_exc_code_o(cp0_exc_code_o), .cp0_exc_bd_o(cp0_exc_bd_o),
        .cp0_exc_epc_o(cp0_exc_epc_o), .cp0_badvaddr_we_o(cp0_badvaddr_we_o),
        .cp0_badvaddr_o(cp0_badvaddr_o), .cp0_eret_we_o(cp0_eret_we_o),
        .cp0_ip_hw_o(cp0_ip_hw_o), .mem_kill_o(mem_kill_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r, v, ds, er, sy, bk, ri, ov, aif, ald, aes;
        logic [31:0] pc, bva, st, epc;
        logic [1:0]  sw;
        logic [5:0]  hw;
    } stim_t;

    typedef struct {
        int          due;
        logic        eret;
        logic [31:0] redir;
        logic [4:0]  code;
        logic        bd;
        logic [31:0] epc;
        logic        bvwe;
        logic [31:0] bv;
    } exp_t;

    exp_t        sb[$];
    int          total = 0, bad = 0, cyc = 0, avail = 0;
    logic        started = 1'b0, exp_kill = 1'b0;
    logic [5:0]  s1_m = '0, ip_m = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{r: 1'b1, v: 1'b0, ds: 1'b0, er: 1'b0, sy: 1'b0, bk: 1'b0, ri: 1'b0, ov: 1'b0,
              aif: 1'b0, ald: 1'b0, aes: 1'b0, pc: 32'h0, bva: 32'h0, st: 32'h0,
              epc: 32'h0, sw: 2'b00, hw: 6'h0};
        return s;
    endfunction

    // Reference: ordered exception table, first raised entry wins; ERET only if none.
    task automatic step(input stim_t s);
        logic       flags[8];
        logic [4:0] codes[8];
        int         bsrc[8];
        logic       irq;
        exp_t       e;
        int         k;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            s1_m  = '0;
            ip_m  = '0;
            avail = cyc;
        end else begin
            ip_m = s1_m;
            s1_m = hw_int_i;
        end
        #1;
        rst = s.r; mem_valid_i = s.v; mem_in_delayslot_i = s.ds; mem_eret_i = s.er;
        mem_syscall_i = s.sy; mem_break_i = s.bk; mem_ri_i = s.ri; mem_ov_i = s.ov;
        mem_adel_if_i = s.aif; mem_adel_ld_i = s.ald; mem_ades_i = s.aes;
        mem_pc_i = s.pc; mem_bad_vaddr_i = s.bva; cp0_status_i = s.st; cp0_epc_i = s.epc;
        cp0_cause_ip_sw_i = s.sw; hw_int_i = s.hw;

        irq   = s.st[0] && !s.st[1] && (({ip_m, s.sw} & s.st[15:8]) != 8'h00);
        flags = '{irq, s.aif, s.ri, s.ov, s.sy, s.bk, s.ald, s.aes};
        codes = '{5'h00, 5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, 5'h04, 5'h05};
        bsrc  = '{0, 1, 0, 0, 0, 0, 2, 2};
        exp_kill = 1'b0;
        if (s.r && s.v && cyc >= avail) begin
            k = -1;
            for (int i = 7; i >= 0; i--) if (flags[i]) k = i;
            e = '{due: cyc + 1, eret: 1'b0, redir: VEC, code: 5'h0, bd: s.ds,
                  epc: s.ds ? s.pc - 32'd4 : s.pc, bvwe: 1'b0, bv: 32'h0};
            if (k >= 0) begin
                e.code = codes[k];
                e.bvwe = (bsrc[k] != 0);
                e.bv   = (bsrc[k] == 1) ? s.pc : s.bva;
            end else if (s.er) begin
                e.eret  = 1'b1;
                e.redir = s.epc;
            end
            if (k >= 0 || s.er) begin
                exp_kill = 1'b1;
                sb.push_back(e);
                avail = cyc + 1 + DRAIN;
            end
        end
        started = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a flush.
    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            chk("ip_hw", {26'h0, cp0_ip_hw_o}, {26'h0, ip_m});
            chk("mem_kill", {31'h0, mem_kill_o}, {31'h0, exp_kill});
            if (sb.size() > 0 && sb[0].due < cyc) begin
                chk("missing_flush", 32'd0, 32'd1);
                void'(sb.pop_front());
            end
            if (flush_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_flush", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("flush_cycle", cyc, e.due);
                    chk("redirect_pc", redirect_pc_o, e.redir);
                    chk("eret_we", {31'h0, cp0_eret_we_o}, {31'h0, e.eret});
                    chk("exc_we", {31'h0, cp0_exc_we_o}, {31'h0, !e.eret});
                    if (!e.eret) begin
                        chk("exc_code", {27'h0, cp0_exc_code_o}, {27'h0, e.code});
                        chk("exc_bd", {31'h0, cp0_exc_bd_o}, {31'h0, e.bd});
                        chk("exc_epc", cp0_exc_epc_o, e.epc);
                        chk("badvaddr_we", {31'h0, cp0_badvaddr_we_o}, {31'h0, e.bvwe});
                        if (e.bvwe) chk("badvaddr", cp0_badvaddr_o, e.bv);
                    end else begin
                        chk("badvaddr_we", {31'h0, cp0_badvaddr_we_o}, 32'h0);
                    end
                end
            end else begin
                chk("idle_pulses", {29'h0, cp0_exc_we_o, cp0_eret_we_o, cp0_badvaddr_we_o}, 32'h0);
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {26'h0, flush_o, cp0_exc_we_o, cp0_badvaddr_we_o, cp0_eret_we_o,
                             cp0_exc_bd_o, mem_kill_o}, 32'h0);
        chk({tag, "_data"}, redirect_pc_o | cp0_exc_epc_o | cp0_badvaddr_o | {27'h0, cp0_exc_code_o}, 32'h0);
    endtask

    initial begin
        stim_t s;
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        s = idle(); s.r = 1'b0;
        repeat (3) step(s);
        @(negedge clk); #1;
        chk_all_zero("reset");
        chk("reset_ip", {26'h0, cp0_ip_hw_o}, 32'h0);

        step(idle());
        // Syscall, no delay slot, then drain window
        s = idle(); s.v = 1; s.sy = 1; s.pc = 32'hBFC00100; step(s);
        repeat (3) step(idle());
        // Overflow in a delay slot
        s = idle(); s.v = 1; s.ov = 1; s.ds = 1; s.pc = 32'h80001008; step(s);
        repeat (3) step(idle());
        // Load AdEL and RI together: RI wins
        s = idle(); s.v = 1; s.ald = 1; s.ri = 1; s.pc = 32'h80000200; s.bva = 32'h80000003; step(s);
        repeat (3) step(idle());
        // Hardware interrupt 0 through the synchroniser
        s = idle(); s.hw = 6'h01; s.st = 32'h00000401; repeat (3) step(s);
        s.v = 1; s.pc = 32'h80000010; step(s);
        s.v = 0; repeat (3) step(s);
        s.st = 32'h00000403; s.v = 1; s.pc = 32'h80000020; step(s);
        s.v = 0; s.hw = 6'h00; repeat (3) step(s);
        // ERET, then syscalls during COMMIT/DRAIN are ignored until the window ends
        s = idle(); s.v = 1; s.er = 1; s.epc = 32'h80000400; s.pc = 32'h80000300; step(s);
        s = idle(); s.v = 1; s.sy = 1; s.pc = 32'h80000304; step(s); step(s); step(s);
        repeat (3) step(idle());
        // Interrupt and ERET on the same instruction
        s = idle(); s.sw = 2'b01; s.st = 32'h00000101; s.v = 1; s.er = 1;
        s.pc = 32'h80000500; s.epc = 32'h80000404; step(s);
        repeat (3) step(idle());
        // Reset during COMMIT
        s = idle(); s.v = 1; s.sy = 1; s.pc = 32'h80000600; step(s);
        s = idle(); s.r = 1'b0; step(s);
        step(idle());
        @(negedge clk); #1;
        chk_all_zero("reset_commit");
        s = idle(); s.v = 1; s.sy = 1; s.pc = 32'h80000700; step(s);
        repeat (3) step(idle());

        // Randomised traffic
        s = idle();
        for (int n = 0; n < 600; n++) begin
            s.r   = ($urandom_range(0, 99) != 0);
            s.v   = ($urandom_range(0, 9) < 7);
            s.ds  = $urandom_range(0, 1);
            s.er  = ($urandom_range(0, 7) == 0);
            s.sy  = ($urandom_range(0, 9) == 0);
            s.bk  = ($urandom_range(0, 9) == 0);
            s.ri  = ($urandom_range(0, 11) == 0);
            s.ov  = ($urandom_range(0, 11) == 0);
            s.aif = ($urandom_range(0, 15) == 0);
            s.ald = ($urandom_range(0, 11) == 0);
            s.aes = ($urandom_range(0, 11) == 0);
            s.pc  = {$urandom} & 32'hFFFF_FFFC;
            s.bva = $urandom;
            s.epc = $urandom;
            if ($urandom_range(0, 19) == 0) s.hw = 6'($urandom);
            if ($urandom_range(0, 29) == 0) s.sw = 2'($urandom);
            case ($urandom_range(0, 3))
                0: s.st = 32'h00000401;
                1: s.st = 32'h0000FF01;
                2: s.st = 32'h0000FF03;
                default: s.st = 32'h00000000;
            endcase
            step(s);
        end
        s = idle(); s.hw = 6'h00;
        repeat (5) step(s);
        @(negedge clk); #1;
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- MEM-stage exception controller for the 5-stage MIPS core.
- Collects per-instruction exception flags: the decode-stage flags (eret, syscall, break, invalid instruction), the EX overflow result, and the address-error flags.
- Samples hardware interrupts, picks the highest-priority event, and commits it to CP0 (Cause/EPC/BadVAddr/Status.EXL).
- Drives the pipeline flush and the redirect PC, and holds off new exceptions for a drain window while the flush propagates.

Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception entry PC.
- DRAIN_CYCLES, 2, cycles after commit during which new exceptions are masked (1..7).
- HW_INT_W, 6, number of hardware interrupt lines.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-low
- mem_valid  in  1  a real (non-bubble) instruction is in MEM
- mem_pc  in  32  PC of the MEM instruction
- mem_in_delayslot  in  1  MEM instruction sits in a branch delay slot
- mem_eret, mem_syscall, mem_break, mem_ri  in  1 each  decode flags carried to MEM
- mem_ov  in  1  overflow actually occurred (add/sub/addi)
- mem_adel_if  in  1  fetch address error
- mem_adel_ld  in  1  load address error
- mem_ades  in  1  store address error
- mem_bad_vaddr  in  32  faulting data address
- hw_int  in  HW_INT_W  asynchronous interrupt lines
- cp0_status  in  32  current Status (IE=bit0, EXL=bit1, IM=bits15:8)
- cp0_cause_ip_sw  in  2  Cause.IP[1:0]
- cp0_epc  in  32  current EPC
- flush  out  1  one-cycle pipeline flush
- redirect_pc  out  32  new fetch PC, valid with flush
- cp0_exc_we  out  1  commit Cause.ExcCode/BD, EPC, EXL=1
- cp0_exc_code  out  5  ExcCode
- cp0_exc_bd  out  1  Cause.BD
- cp0_exc_epc  out  32  EPC value
- cp0_badvaddr_we  out  1  BadVAddr write
- cp0_badvaddr  out  32  BadVAddr value
- cp0_eret_we  out  1  clear Status.EXL
- cp0_ip_hw  out  HW_INT_W  synchronised IP[7:2] for Cause
- mem_kill  out  1  combinational: suppress MEM-stage memory write / regfile write this cycle

Behaviour:
- Reset (rst==0 at posedge): all outputs 0, FSM=IDLE, drain counter 0, interrupt sync flops 0.
- hw_int passes through a 2-flop synchroniser; cp0_ip_hw = second flop.
- Interrupt pending: irq = cp0_status[0] & ~cp0_status[1] & |({cp0_ip_hw, cp0_cause_ip_sw} & cp0_status[15:8]).
- Events are considered only when mem_valid=1 and FSM=IDLE.
- Priority, high to low:
  - Int: 0x00
  - AdEL_if: 0x04, BadVAddr=mem_pc
  - RI: 0x0A
  - Ov: 0x0C
  - Sys: 0x08
  - Bp: 0x09
  - AdEL_ld: 0x04, BadVAddr=mem_bad_vaddr
  - AdES: 0x05, BadVAddr=mem_bad_vaddr
  - ERET: lowest; ignored if any exception above is present.
- mem_kill is combinational, asserted in the same cycle as the detected event.
- FSM states:
  - IDLE, event found: register the outputs and go to COMMIT.
  - COMMIT (1 cycle): flush=1.
    - Exception: cp0_exc_we=1, redirect_pc=EXC_VECTOR.
    - ERET: cp0_eret_we=1, redirect_pc=cp0_epc sampled at detection.
    - cp0_badvaddr_we=1 only for address errors.
    - Next state DRAIN, counter loaded with DRAIN_CYCLES-1.
  - DRAIN: all pulses 0; mem_valid events ignored; counter decrements; at 0 return to IDLE.
- EPC and BD: if mem_in_delayslot, EPC = mem_pc-4 and BD=1; else EPC = mem_pc and BD=0. Arithmetic is 32-bit wrap.
- Latency: event in cycle N gives flush and CP0 writes in cycle N+1; first new event is accepted in cycle N+1+DRAIN_CYCLES.
- Interrupt and ERET on the same instruction: the interrupt wins and EPC = that ERET's PC.
- Multiple flags on one instruction: only the highest-priority one is committed.
- If irq asserts while in COMMIT or DRAIN, it stays pending and is taken at the first valid IDLE cycle.
- If reset asserts mid-COMMIT or mid-DRAIN: outputs clear the same edge and no partial CP0 write survives.

Decomposition:
- Shared package/include (cp0 header): ExcCode constants (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV), Status/Cause bit-position constants, FSM state encodings.
- One sub-module: exc_prio_enc, a combinational priority encoder that takes the flags and irq and returns {hit, is_eret, code, badvaddr_we, badvaddr_sel}.

Test Plan:
- Syscall at mem_pc=0xBFC00100, no delay slot: next cycle flush=1, redirect_pc=0xBFC00380, code=0x08, epc=0xBFC00100, bd=0; then 2 drain cycles with all pulses 0.
- Overflow in delay slot at pc=0x80001008: code=0x0C, epc=0x80001004, bd=1.
- Load AdEL with bad_vaddr=0x80000003 plus RI on the same instruction: RI wins, code=0x0A, cp0_badvaddr_we=0.
- hw_int[0] asserted with Status=0x0000_0401: cp0_ip_hw[0]=1 after 2 cycles; next valid instruction commits code=0x00. Repeat with EXL=1: no exception.
- ERET with cp0_epc=0x80000400: cp0_eret_we=1, redirect_pc=0x80000400, cp0_exc_we=0. A syscall presented during DRAIN is ignored.
- rst=0 in the COMMIT cycle: all outputs 0 next edge, FSM=IDLE; a following syscall is handled normally.
